// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM states, owner IDs and the
// legal MEM_LAT range.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_LS = 1'b0;
    localparam logic OWN_IF = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational LS/IF grant picker. Define DMEM_ARB_RR_EN for round-robin;
// otherwise LS always beats IF.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic ls_req,
    input  logic if_req,
    input  logic enable,
    input  logic last_owner,
    output logic ls_gnt,
    output logic if_gnt
);

    logic ls_wins;

`ifdef DMEM_ARB_RR_EN
    // On a tie, whoever did not win last time goes first.
    assign ls_wins = ls_req && (!if_req || (last_owner == OWN_IF));
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign ls_wins = ls_req;
`endif

    assign ls_gnt = enable && ls_wins;
    assign if_gnt = enable && if_req && !ls_wins;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data/instruction memory between load/store and fetch.
// Optional round-robin arbitration via DMEM_ARB_RR_EN (see dmem_arb_pick).
//
// state | meaning
// IDLE  | arbitrate; grants only here
// ISSUE | mem_en high for one cycle; stores return to IDLE
// WAIT  | count MEM_LAT cycles, capture mem_rdata in the last one
// RESP  | owner's rvalid pulse
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = $clog2(MEM_LAT + 1);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("dmem_arbiter: MEM_LAT must be within 1..15");
    end

    state_t        state;
    logic          owner;
    logic          last_owner;
    logic [CW-1:0] cnt;
    logic          pick_en;
    logic          gnt_owner;

    assign pick_en   = (state == IDLE) && reset_n;
    assign gnt_owner = if_gnt ? OWN_IF : OWN_LS;
    assign busy      = (state != IDLE);

    dmem_arb_pick u_pick (
        .ls_req     (ls_req),
        .if_req     (if_req),
        .enable     (pick_en),
        .last_owner (last_owner),
        .ls_gnt     (ls_gnt),
        .if_gnt     (if_gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= OWN_LS;
            last_owner <= OWN_IF;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ls_rvalid  <= 1'b0;
            if_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            if_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ls_gnt || if_gnt) begin
                        state      <= ISSUE;
                        owner      <= gnt_owner;
                        last_owner <= gnt_owner;
                        mem_en     <= 1'b1;
                        mem_we     <= ls_gnt && ls_we;
                        mem_addr   <= ls_gnt ? ls_addr : if_addr;
                        // Fetches carry no write data, so the last store data is kept.
                        if (ls_gnt) mem_wdata <= ls_wdata;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                        cnt   <= CW'(MEM_LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                        if (owner == OWN_LS) begin
                            ls_rdata  <= mem_rdata;
                            ls_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    ls_rvalid <= 1'b0;
                    if_rvalid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (MEM_LAT=2): per-cycle timing model plus
// directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ls_req = 1'b0, ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Memory: read data appears only in the cycle MEM_LAT after mem_en.
    int          slot_c [0:31];
    logic [31:0] slot_d [0:31];
    initial for (int i = 0; i < 32; i++) slot_c[i] = -1;

    always @(negedge clk) begin
        if (mem_en && !mem_we) begin
            slot_c[(cyc + LAT) % 32] = cyc + LAT;
            slot_d[(cyc + LAT) % 32] = memf(mem_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        if (slot_c[cyc % 32] == cyc) mem_rdata = slot_d[cyc % 32];
        else                         mem_rdata = 32'hBADC_0000 | cyc[15:0];
    end

    // Observation monitors used by the directed scenarios.
    int          en_cyc = -1, ls_rv_cyc = -1, if_rv_cyc = -1;
    logic [31:0] en_addr, en_wdata, ls_rv_dat, if_rv_dat;
    logic        en_we;
    int          gq[$];

    always @(negedge clk) begin
        if (mem_en) begin
            en_cyc = cyc; en_addr = mem_addr; en_wdata = mem_wdata; en_we = mem_we;
        end
        if (ls_rvalid) begin ls_rv_cyc = cyc; ls_rv_dat = ls_rdata; end
        if (if_rvalid) begin if_rv_cyc = cyc; if_rv_dat = if_rdata; end
        if (reset_n && ls_gnt) gq.push_back(0);
        if (reset_n && if_gnt) gq.push_back(1);
    end

    // Reference model: timing derived from grant cycle arithmetic.
    int          m_next_ok = 0, m_busy_lo = -1, m_busy_hi = -1;
    int          m_en_cyc = -1, m_rv_cyc = -1;
    logic        m_en_we = 1'b0, m_rv_own = 1'b0, m_last = 1'b1;
    logic [31:0] m_en_wdata = '0, m_rv_data = '0, m_addr_hold = '0;
    logic [31:0] m_ls_rd = '0, m_if_rd = '0;
    logic        e_lg, e_ig, e_lrv, e_irv, e_busy, e_en;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ls_gnt", ls_gnt, 0);
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_ls_rvalid", ls_rvalid, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_ls_rdata", ls_rdata, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            m_next_ok = 0; m_busy_lo = -1; m_busy_hi = -1;
            m_en_cyc = -1; m_rv_cyc = -1; m_last = 1'b1;
            m_ls_rd = '0; m_if_rd = '0; m_addr_hold = '0; m_en_wdata = '0;
        end else begin
            e_lrv = (cyc == m_rv_cyc) && !m_rv_own;
            e_irv = (cyc == m_rv_cyc) && m_rv_own;
            if (e_lrv) m_ls_rd = m_rv_data;
            if (e_irv) m_if_rd = m_rv_data;
            e_busy = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
            e_en   = (cyc == m_en_cyc);
            e_lg = 1'b0; e_ig = 1'b0;
            if (cyc >= m_next_ok) begin
`ifdef DMEM_ARB_RR_EN
                if (ls_req && if_req) begin e_lg = m_last; e_ig = !m_last; end
                else begin e_lg = ls_req; e_ig = if_req; end
`else
                e_lg = ls_req; e_ig = if_req && !ls_req;
`endif
            end
            chk("ls_gnt", ls_gnt, e_lg);
            chk("if_gnt", if_gnt, e_ig);
            chk("busy", busy, e_busy);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_en && m_en_we);
            chk("mem_addr", mem_addr, m_addr_hold);
            if (e_en && m_en_we) chk("mem_wdata", mem_wdata, m_en_wdata);
            chk("ls_rvalid", ls_rvalid, e_lrv);
            chk("if_rvalid", if_rvalid, e_irv);
            chk("ls_rdata", ls_rdata, m_ls_rd);
            chk("if_rdata", if_rdata, m_if_rd);
            if (e_lg || e_ig) begin
                m_last      = e_ig;
                m_addr_hold = e_lg ? ls_addr : if_addr;
                m_en_cyc    = cyc + 1;
                m_en_we     = e_lg && ls_we;
                m_en_wdata  = ls_wdata;
                m_busy_lo   = cyc + 1;
                if (m_en_we) begin
                    m_busy_hi = cyc + 1; m_next_ok = cyc + 2; m_rv_cyc = -1;
                end else begin
                    m_busy_hi = cyc + 2 + LAT; m_next_ok = cyc + 3 + LAT;
                    m_rv_cyc  = cyc + 2 + LAT; m_rv_own = e_ig;
                    m_rv_data = memf(m_addr_hold);
                end
            end
        end
    end

    // Requesters: hold req until granted, then scramble request fields.
    task automatic ls_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int gcyc);
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        gcyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ls_gnt) begin gcyc = cyc; break; end
        end
        n_cmp++;
        if (gcyc < 0) begin n_fail++; $display("FAIL ls_gnt_timeout got=none want=grant"); end
        @(posedge clk); #1;
        ls_req = 1'b0; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom; ls_wdata = $urandom;
    endtask

    task automatic if_op(input logic [31:0] addr, output int gcyc);
        if_req = 1'b1; if_addr = addr;
        gcyc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (if_gnt) begin gcyc = cyc; break; end
        end
        n_cmp++;
        if (gcyc < 0) begin n_fail++; $display("FAIL if_gnt_timeout got=none want=grant"); end
        @(posedge clk); #1;
        if_req = 1'b0; if_addr = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    int g0, g1, g2, ga, gb, rel, ls_before;

    initial begin
        repeat (3) @(posedge clk);
        #1; reset_n = 1'b1; rel = cyc;

        // Load 0x100 right after reset.
        ls_op(1'b0, 32'h100, 32'h0, g0);
        chk("load_first_gnt", g0, rel);
        repeat (5) @(posedge clk); #1;
        chk("load_en_cyc", en_cyc, g0 + 1);
        chk("load_en_addr", en_addr, 32'h100);
        chk("load_rv_cyc", ls_rv_cyc, g0 + 4);
        chk("load_rv_data", ls_rv_dat, 32'hDEADBEEF);

        // Store 0x40, then a load requested immediately behind it.
        ls_before = ls_rv_cyc;
        ls_op(1'b1, 32'h40, 32'h12345678, g1);
        ls_op(1'b0, 32'h44, 32'h0, g2);
        chk("store_en_cyc", en_cyc, g1 + 1);
        chk("store_en_we", en_we, 1);
        chk("store_en_addr", en_addr, 32'h40);
        chk("store_en_wdata", en_wdata, 32'h12345678);
        chk("store_next_gnt", g2 - g1, 2);
        chk("store_no_rvalid", ls_rv_cyc, ls_before);
        repeat (5) @(posedge clk); #1;

        // Lone fetch (also leaves IF as last owner).
        if_op(32'h80, g0);
        repeat (5) @(posedge clk); #1;
        chk("fetch_rv_cyc", if_rv_cyc, g0 + 4);
        chk("fetch_rv_data", if_rv_dat, memf(32'h80));

        // Both requesters held for two grants each.
        gq.delete();
        fork
            begin ls_op(1'b0, 32'h200, 32'h0, ga); ls_op(1'b0, 32'h204, 32'h0, ga); end
            begin if_op(32'h300, gb); if_op(32'h304, gb); end
        join
        repeat (5) @(posedge clk); #1;
        chk("both_gnt_count", gq.size(), 4);
        if (gq.size() == 4) begin
`ifdef DMEM_ARB_RR_EN
            chk("rr_order0", gq[0], 0); chk("rr_order1", gq[1], 1);
            chk("rr_order2", gq[2], 0); chk("rr_order3", gq[3], 1);
`else
            chk("fix_order0", gq[0], 0); chk("fix_order1", gq[1], 0);
            chk("fix_order2", gq[2], 1); chk("fix_order3", gq[3], 1);
`endif
        end

        // Fetch requested while a load is in flight.
        ls_op(1'b0, 32'h500, 32'h0, g1);
        if_op(32'h600, g2);
        chk("if_after_load_gnt", g2 - g1, 5);
        repeat (5) @(posedge clk); #1;
        chk("inflight_ls_rv_cyc", ls_rv_cyc, g1 + 4);
        chk("inflight_ls_rv_data", ls_rv_dat, memf(32'h500));
        chk("inflight_if_rv_cyc", if_rv_cyc, g2 + 4);
        chk("inflight_if_rv_data", if_rv_dat, memf(32'h600));

        // Reset during the WAIT phase of a fetch.
        if_op(32'h700, g0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_if_rvalid", if_rvalid, 0);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1; rel = cyc;
        if_op(32'h704, g1);
        chk("abort_regrant_cyc", g1, rel);
        repeat (5) @(posedge clk); #1;
        chk("abort_rv_cyc", if_rv_cyc, g1 + 4);
        chk("abort_rv_data", if_rv_dat, memf(32'h704));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
